// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and framing constants.
package inst_loader_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StWrite = 3'd2,
        StDone  = 3'd3,
        StErr   = 3'd4
    } state_e;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam int unsigned BYTES_PER_WORD    = 4;

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Shifts received bytes MSB-first into a 32-bit word and flags the cycle after the 4th byte.
module inst_loader_byte_assembler
    import inst_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [31:0] word,
    output logic        word_ready,
    output logic        last_byte
);

    logic [1:0]  cnt_q;
    logic [31:0] word_q;
    logic        ready_q;

    // High while the next accepted byte completes the word.
    assign last_byte = (cnt_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= 2'd0;
            word_q  <= 32'd0;
            ready_q <= 1'b0;
        end else if (clear) begin
            cnt_q   <= 2'd0;
            word_q  <= 32'd0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= rx_done && last_byte;
            if (rx_done) begin
                word_q <= {word_q[23:0], rx_data};
                cnt_q  <= cnt_q + 2'd1;
            end
        end
    end

    assign word       = word_q;
    assign word_ready = ready_q;

endmodule

// File: rtl/inst_loader.sv
// Loads a UART byte stream into instruction memory while holding the CPU, then restarts the PC.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_done,
    output logic                  wr_en,
    output logic [ADDR_BITS-1:0]  wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  cpu_hold,
    output logic                  pc_reset_out,
    output logic                  load_done,
    output logic                  overflow_err,
    output logic [ADDR_BITS-1:0]  word_count
);

    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_e               state_q, state_d;
    logic [AW-1:0]        addr_q;
    logic [ADDR_BITS-1:0] count_q;
    logic                 cpu_hold_q;
    logic                 pc_reset_q;
    logic                 load_done_q;
    logic                 overflow_q;

    logic                 start_load;
    logic                 asm_rx_done;
    logic                 last_byte;
    logic                 word_ready;
    logic [31:0]          word;

    assign start_load  = start && ((state_q == StIdle) || (state_q == StErr));
    // Bytes arriving during WRITE start the next word, so none are dropped.
    assign asm_rx_done = rx_done && ((state_q == StLoad) || (state_q == StWrite));

    inst_loader_byte_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_load),
        .rx_data    (rx_data),
        .rx_done    (asm_rx_done),
        .word       (word),
        .word_ready (word_ready),
        .last_byte  (last_byte)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StErr: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                if (asm_rx_done && last_byte) state_d = StWrite;
            end
            StWrite: begin
                if (word == HALT_WORD) begin
                    state_d = StDone;
                end else if (addr_q == AW'(MEM_DEPTH - 1)) begin
                    state_d = StErr;
                end else begin
                    state_d = StLoad;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            count_q     <= '0;
            cpu_hold_q  <= 1'b0;
            pc_reset_q  <= 1'b0;
            load_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpu_hold_q <= (state_d != StIdle);
            pc_reset_q <= (state_d == StDone);
            if (start_load) begin
                addr_q      <= '0;
                count_q     <= '0;
                load_done_q <= 1'b0;
                overflow_q  <= 1'b0;
            end else begin
                if (state_q == StWrite) begin
                    addr_q  <= addr_q + AW'(1);
                    count_q <= count_q + ADDR_BITS'(1);
                end
                if (state_q == StDone) load_done_q <= 1'b1;
                if (state_d == StErr)  overflow_q  <= 1'b1;
            end
        end
    end

    // word_ready is a registered pulse that coincides exactly with the WRITE cycle.
    assign wr_en        = word_ready;
    assign wr_addr      = ADDR_BITS'(addr_q);
    assign wr_data      = word;
    assign cpu_hold     = cpu_hold_q;
    assign pc_reset_out = pc_reset_q;
    assign load_done    = load_done_q;
    assign overflow_err = overflow_q;
    assign word_count   = count_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: a full-depth instance plus a MEM_DEPTH=4 instance for overflow.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_done;

    logic        wr_en_a, cpu_hold_a, pc_reset_a, load_done_a, overflow_a;
    logic [31:0] wr_addr_a, wr_data_a, word_count_a;
    logic        wr_en_b, cpu_hold_b, pc_reset_b, load_done_b, overflow_b;
    logic [31:0] wr_addr_b, wr_data_b, word_count_b;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int wr_cnt_b = 0;
    int pc_cnt_b = 0;

    inst_loader u_dut_a (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .wr_en        (wr_en_a),
        .wr_addr      (wr_addr_a),
        .wr_data      (wr_data_a),
        .cpu_hold     (cpu_hold_a),
        .pc_reset_out (pc_reset_a),
        .load_done    (load_done_a),
        .overflow_err (overflow_a),
        .word_count   (word_count_a)
    );

    inst_loader #(.MEM_DEPTH(4)) u_dut_b (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .wr_en        (wr_en_b),
        .wr_addr      (wr_addr_b),
        .wr_data      (wr_data_b),
        .cpu_hold     (cpu_hold_b),
        .pc_reset_out (pc_reset_b),
        .load_done    (load_done_b),
        .overflow_err (overflow_b),
        .word_count   (word_count_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en_b)    wr_cnt_b <= wr_cnt_b + 1;
        if (pc_reset_b) pc_cnt_b <= pc_cnt_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[31:24]);
        send(w[23:16]);
        send(w[15:8]);
        send(w[7:0]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int wbase;
        int pbase;
        reset   = 1'b1;
        start   = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        #2;
        check("rst_wr_en", 32'(wr_en_a), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold_a), 32'd0);
        check("rst_load_done", 32'(load_done_a), 32'd0);
        check("rst_word_count", word_count_a, 32'd0);
        check("rst_wr_data", wr_data_a, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Basic two-word program ending in the halt word
        pulse_start();
        check("t1_hold", 32'(cpu_hold_a), 32'd1);
        send_word(32'h2010_0005);
        check("t1_w0_en", 32'(wr_en_a), 32'd1);
        check("t1_w0_addr", wr_addr_a, 32'd0);
        check("t1_w0_data", wr_data_a, 32'h2010_0005);
        tick();
        check("t1_en_low", 32'(wr_en_a), 32'd0);
        check("t1_cnt1", word_count_a, 32'd1);
        send_word(32'hFFFF_FFFF);
        check("t1_w1_addr", wr_addr_a, 32'd1);
        check("t1_w1_data", wr_data_a, 32'hFFFF_FFFF);
        tick();
        check("t1_pcrst", 32'(pc_reset_a), 32'd1);
        check("t1_hold_done", 32'(cpu_hold_a), 32'd1);
        tick();
        check("t1_pcrst_off", 32'(pc_reset_a), 32'd0);
        check("t1_hold_off", 32'(cpu_hold_a), 32'd0);
        check("t1_load_done", 32'(load_done_a), 32'd1);
        check("t1_cnt2", word_count_a, 32'd2);
        check("t1_no_ovf", 32'(overflow_a), 32'd0);

        // Byte arriving in the WRITE cycle starts the next word
        pulse_start();
        check("t2_done_clr", 32'(load_done_a), 32'd0);
        check("t2_cnt_clr", word_count_a, 32'd0);
        send_word(32'h0000_00AB);
        check("t2_w0_data", wr_data_a, 32'h0000_00AB);
        send(8'h12);
        send(8'h34);
        send(8'h56);
        send(8'h78);
        check("t2_w1_en", 32'(wr_en_a), 32'd1);
        check("t2_w1_addr", wr_addr_a, 32'd1);
        check("t2_w1_data", wr_data_a, 32'h1234_5678);
        tick();
        send_word(32'hFFFF_FFFF);
        check("t2_w2_addr", wr_addr_a, 32'd2);
        tick();
        tick();
        check("t2_cnt3", word_count_a, 32'd3);
        check("t2_load_done", 32'(load_done_a), 32'd1);

        // start mid-LOAD is ignored; rx_done in IDLE is ignored
        pulse_start();
        send(8'hDE);
        send(8'hAD);
        pulse_start();
        check("t3_hold", 32'(cpu_hold_a), 32'd1);
        send(8'hBE);
        send(8'hEF);
        check("t3_w0_addr", wr_addr_a, 32'd0);
        check("t3_w0_data", wr_data_a, 32'hDEAD_BEEF);
        tick();
        send_word(32'hFFFF_FFFF);
        check("t3_w1_addr", wr_addr_a, 32'd1);
        tick();
        tick();
        check("t3_cnt2", word_count_a, 32'd2);
        send(8'h55);
        check("t3_idle_no_wr", 32'(wr_en_a), 32'd0);
        tick();
        check("t3_idle_no_wr2", 32'(wr_en_a), 32'd0);
        check("t3_idle_cnt", word_count_a, 32'd2);

        // Asynchronous reset in the middle of a load
        pulse_start();
        send_word(32'h0101_0101);
        tick();
        send_word(32'h0202_0202);
        tick();
        send(8'h33);
        #2;
        reset = 1'b1;
        #1;
        check("t4_hold", 32'(cpu_hold_a), 32'd0);
        check("t4_cnt", word_count_a, 32'd0);
        check("t4_addr", wr_addr_a, 32'd0);
        check("t4_data", wr_data_a, 32'd0);
        check("t4_wr_en", 32'(wr_en_a), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        pulse_start();
        send_word(32'h1122_3344);
        check("t4_w0_addr", wr_addr_a, 32'd0);
        check("t4_w0_data", wr_data_a, 32'h1122_3344);
        tick();
        send_word(32'hFFFF_FFFF);
        check("t4_w1_addr", wr_addr_a, 32'd1);
        tick();
        check("t4_pcrst", 32'(pc_reset_a), 32'd1);
        tick();

        // Overflow on the depth-4 instance
        pbase = pc_cnt_b;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send_word(32'hA000_0000 + 32'(i));
            check("t5_addr", wr_addr_b, 32'(i));
            check("t5_data", wr_data_b, 32'hA000_0000 + 32'(i));
            if (i < 3) tick();
        end
        tick();
        check("t5_ovf", 32'(overflow_b), 32'd1);
        check("t5_hold", 32'(cpu_hold_b), 32'd1);
        check("t5_pcrst", 32'(pc_reset_b), 32'd0);
        check("t5_cnt4", word_count_b, 32'd4);
        check("t5_no_done", 32'(load_done_b), 32'd0);
        wbase = wr_cnt_b;
        send_word(32'h1234_5678);
        tick();
        tick();
        check("t5_no_more_wr", 32'(wr_cnt_b), 32'(wbase));
        check("t5_ovf_sticky", 32'(overflow_b), 32'd1);
        check("t5_no_pcrst", 32'(pc_cnt_b), 32'(pbase));
        pulse_start();
        check("t5_ovf_clr", 32'(overflow_b), 32'd0);
        check("t5_addr_clr", wr_addr_b, 32'd0);
        check("t5_hold_rst", 32'(cpu_hold_b), 32'd1);
        send_word(32'hCAFE_F00D);
        check("t5_re_en", 32'(wr_en_b), 32'd1);
        check("t5_re_addr", wr_addr_b, 32'd0);
        tick();
        send_word(32'hFFFF_FFFF);
        tick();
        tick();
        check("t5_re_done", 32'(load_done_b), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
